// File: rtl/dwa_pkg.sv
// Shared widths and the mod-WIDTH rotation helper for the DWA rotator.
package dwa_pkg;

    localparam int unsigned MaxWidth = 64;
    localparam int unsigned MaxIdxW  = 6;

    function automatic int unsigned cnt_w(input int unsigned width);
        return unsigned'($clog2(width + 1));
    endfunction

    function automatic int unsigned ptr_w(input int unsigned width);
        return (width > 2) ? unsigned'($clog2(width)) : 1;
    endfunction

    // Left-rotate the low 'width' bits of mask by amount (amount < width), wrapping at width.
    function automatic logic [MaxWidth-1:0] rotl(input logic [MaxWidth-1:0] mask,
                                                  input logic [MaxIdxW-1:0]  amount,
                                                  input logic [MaxIdxW:0]    width);
        logic [MaxWidth-1:0] r;
        logic [MaxIdxW:0]    j;
        r = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            if (i < int'(width)) begin
                j = (MaxIdxW + 1)'(i) + {1'b0, amount};
                if (j >= width) begin
                    j = j - width;
                end
                r[j[MaxIdxW-1:0]] = mask[i[MaxIdxW-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/count2thermometer.sv
// Clamps a unit count to WIDTH and expands it into an LSB-first thermometer mask.
module count2thermometer
    import dwa_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CW    = cnt_w(WIDTH)
) (
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] therm,
    output logic [CW-1:0]    count_clamped,
    output logic             sat
);

    assign sat           = count > CW'(WIDTH);
    assign count_clamped = sat ? CW'(WIDTH) : count;

    for (genvar g = 0; g < WIDTH; g++) begin : g_therm
        assign therm[g] = CW'(g) < count_clamped;
    end

endmodule

// File: rtl/dwa_rotator.sv
// Data-weighted-averaging rotator: rotates a thermometer mask by a running pointer and
// registers the result behind a single-stage valid/ready handshake.
module dwa_rotator
    import dwa_pkg::*;
#(
    parameter  int unsigned WIDTH  = 4,
    parameter  bit          ROTATE = 1'b1,
    localparam int unsigned CW     = cnt_w(WIDTH),
    localparam int unsigned PW     = ptr_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ptr_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sel,
    output logic [PW-1:0]    out_ptr,
    output logic             out_sat
);

    logic [WIDTH-1:0]    therm;
    logic [CW-1:0]       c;
    logic                sat;
    logic                accept;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       p_eff;
    logic [PW:0]         sum;
    logic [PW-1:0]       ptr_next;
    logic [MaxWidth-1:0] rot_full;
    logic [WIDTH-1:0]    sel_next;
    logic                valid_q;
    logic [WIDTH-1:0]    sel_q;
    logic [PW-1:0]       optr_q;
    logic                sat_q;

    count2thermometer #(
        .WIDTH (WIDTH)
    ) u_therm (
        .count         (in_count),
        .therm         (therm),
        .count_clamped (c),
        .sat           (sat)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign p_eff    = (ptr_clr || !ROTATE) ? '0 : ptr_q;

    // p + c < 2*WIDTH, so one conditional subtract gives the modulo without a power-of-two width.
    assign sum      = {1'b0, p_eff} + (PW + 1)'(c);
    assign ptr_next = (sum >= (PW + 1)'(WIDTH)) ? PW'(sum - (PW + 1)'(WIDTH)) : sum[PW-1:0];

    assign rot_full = rotl(MaxWidth'(therm), MaxIdxW'(p_eff), (MaxIdxW + 1)'(WIDTH));
    assign sel_next = rot_full[WIDTH-1:0];

    if (WIDTH < MaxWidth) begin : g_unused
        logic unused_rot;
        assign unused_rot = ^rot_full[MaxWidth-1:WIDTH];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ROTATE ? ptr_next : '0;
        end else if (ptr_clr) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            optr_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                valid_q <= 1'b1;
                sel_q   <= sel_next;
                optr_q  <= p_eff;
                sat_q   <= sat;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign out_ptr   = optr_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_dwa_rotator.sv
// Directed bench for dwa_rotator: WIDTH=4 and WIDTH=5 rotating instances plus a WIDTH=4
// thermometer-mode instance, all fed the same stimulus.
module tb_dwa_rotator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ptr_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_count = '0;
    logic       out_ready = 1'b1;

    logic       in_ready_a, out_valid_a, out_sat_a;
    logic [3:0] out_sel_a;
    logic [1:0] out_ptr_a;
    logic       in_ready_b, out_valid_b, out_sat_b;
    logic [4:0] out_sel_b;
    logic [2:0] out_ptr_b;
    logic       in_ready_c, out_valid_c, out_sat_c;
    logic [3:0] out_sel_c;
    logic [1:0] out_ptr_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dwa_rotator #(.WIDTH(4), .ROTATE(1'b1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .ptr_clr(ptr_clr), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_count(in_count), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sel(out_sel_a), .out_ptr(out_ptr_a), .out_sat(out_sat_a)
    );

    dwa_rotator #(.WIDTH(5), .ROTATE(1'b1)) u_w5 (
        .clk(clk), .rst_n(rst_n), .ptr_clr(ptr_clr), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_count(in_count), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sel(out_sel_b), .out_ptr(out_ptr_b), .out_sat(out_sat_b)
    );

    dwa_rotator #(.WIDTH(4), .ROTATE(1'b0)) u_plain (
        .clk(clk), .rst_n(rst_n), .ptr_clr(ptr_clr), .in_valid(in_valid),
        .in_ready(in_ready_c), .in_count(in_count), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_sel(out_sel_c), .out_ptr(out_ptr_c), .out_sat(out_sat_c)
    );

    task automatic do_reset();
        in_valid  = 1'b0;
        ptr_clr   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One accepted sample; returns 1 time unit after the capturing edge.
    task automatic send(input logic [2:0] cnt, input logic clr);
        in_count = cnt;
        in_valid = 1'b1;
        ptr_clr  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ptr_clr  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({out_valid_a, out_sel_a, out_ptr_a, out_sat_a} !== 8'b0) begin
            fails++;
            $display("FAIL reset_w4: got v=%b sel=%b ptr=%0d sat=%b, expected all zero",
                     out_valid_a, out_sel_a, out_ptr_a, out_sat_a);
        end
        tests++;
        if ({out_valid_b, out_sel_b, out_ptr_b, out_sat_b} !== 10'b0) begin
            fails++;
            $display("FAIL reset_w5: got v=%b sel=%b ptr=%0d sat=%b, expected all zero",
                     out_valid_b, out_sel_b, out_ptr_b, out_sat_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] cnt [5];
        logic [3:0] e4 [5];
        logic [1:0] p4 [5];
        logic [4:0] e5 [5];
        logic [2:0] p5 [5];
        logic [3:0] et [5];
        cnt = '{3'd3, 3'd2, 3'd1, 3'd4, 3'd0};
        e4  = '{4'b0111, 4'b1001, 4'b0010, 4'b1111, 4'b0000};
        p4  = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2};
        e5  = '{5'b00111, 5'b11000, 5'b00001, 5'b11110, 5'b00000};
        p5  = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd0};
        et  = '{4'b0111, 4'b0011, 4'b0001, 4'b1111, 4'b0000};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(cnt[k], 1'b0);
            tests++;
            if (out_valid_a !== 1'b1 || out_sel_a !== e4[k] || out_ptr_a !== p4[k]) begin
                fails++;
                $display("FAIL b2b_w4[%0d]: got v=%b sel=%b ptr=%0d, expected v=1 sel=%b ptr=%0d",
                         k, out_valid_a, out_sel_a, out_ptr_a, e4[k], p4[k]);
            end
            tests++;
            if (out_valid_b !== 1'b1 || out_sel_b !== e5[k] || out_ptr_b !== p5[k]) begin
                fails++;
                $display("FAIL b2b_w5[%0d]: got v=%b sel=%b ptr=%0d, expected v=1 sel=%b ptr=%0d",
                         k, out_valid_b, out_sel_b, out_ptr_b, e5[k], p5[k]);
            end
            tests++;
            if (out_valid_c !== 1'b1 || out_sel_c !== et[k] || out_ptr_c !== 2'd0) begin
                fails++;
                $display("FAIL b2b_plain[%0d]: got v=%b sel=%b ptr=%0d, expected v=1 sel=%b ptr=0",
                         k, out_valid_c, out_sel_c, out_ptr_c, et[k]);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid_a !== 1'b0) begin
            fails++;
            $display("FAIL drain_w4: got out_valid=%b, expected 0", out_valid_a);
        end
    endtask

    task automatic test_w5_wrap();
        logic [4:0] e5 [3];
        logic [2:0] p5 [3];
        e5 = '{5'b01111, 5'b10111, 5'b11011};
        p5 = '{3'd0, 3'd4, 3'd3};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(3'd4, 1'b0);
            tests++;
            if (out_sel_b !== e5[k] || out_ptr_b !== p5[k] || out_sat_b !== 1'b0) begin
                fails++;
                $display("FAIL wrap_w5[%0d]: got sel=%b ptr=%0d sat=%b, expected sel=%b ptr=%0d sat=0",
                         k, out_sel_b, out_ptr_b, out_sat_b, e5[k], p5[k]);
            end
        end
    endtask

    task automatic test_clamp();
        logic [2:0] cnt [4];
        logic [3:0] e4 [4];
        logic [1:0] p4 [4];
        logic       s4 [4];
        logic [4:0] e5 [4];
        logic       s5 [4];
        cnt = '{3'd1, 3'd5, 3'd7, 3'd1};
        e4  = '{4'b0001, 4'b1111, 4'b1111, 4'b0010};
        p4  = '{2'd0, 2'd1, 2'd1, 2'd1};
        s4  = '{1'b0, 1'b1, 1'b1, 1'b0};
        e5  = '{5'b00001, 5'b11111, 5'b11111, 5'b00010};
        s5  = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(cnt[k], 1'b0);
            tests++;
            if (out_sel_a !== e4[k] || out_ptr_a !== p4[k] || out_sat_a !== s4[k]) begin
                fails++;
                $display("FAIL clamp_w4[%0d]: got sel=%b ptr=%0d sat=%b, expected sel=%b ptr=%0d sat=%b",
                         k, out_sel_a, out_ptr_a, out_sat_a, e4[k], p4[k], s4[k]);
            end
            tests++;
            if (out_sel_b !== e5[k] || out_sat_b !== s5[k]) begin
                fails++;
                $display("FAIL clamp_w5[%0d]: got sel=%b sat=%b, expected sel=%b sat=%b",
                         k, out_sel_b, out_sat_b, e5[k], s5[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send(3'd2, 1'b0);
        in_count = 3'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (out_valid_a !== 1'b1 || out_sel_a !== 4'b0011 || in_ready_a !== 1'b0) begin
                fails++;
                $display("FAIL stall_w4[%0d]: got v=%b sel=%b in_ready=%b, expected v=1 sel=0011 in_ready=0",
                         k, out_valid_a, out_sel_a, in_ready_a);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready_a !== 1'b1) begin
            fails++;
            $display("FAIL ready_comb_w4: got in_ready=%b, expected 1", in_ready_a);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'b0100 || out_ptr_a !== 2'd2) begin
            fails++;
            $display("FAIL release_w4: got v=%b sel=%b ptr=%0d, expected v=1 sel=0100 ptr=2",
                     out_valid_a, out_sel_a, out_ptr_a);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid_a !== 1'b0) begin
            fails++;
            $display("FAIL no_dup_w4: got out_valid=%b, expected 0", out_valid_a);
        end
    endtask

    task automatic test_ptr_clr();
        do_reset();
        send(3'd2, 1'b0);
        send(3'd3, 1'b1);
        tests++;
        if (out_sel_a !== 4'b0111 || out_ptr_a !== 2'd0) begin
            fails++;
            $display("FAIL clr_accept_w4: got sel=%b ptr=%0d, expected sel=0111 ptr=0",
                     out_sel_a, out_ptr_a);
        end
        send(3'd1, 1'b0);
        tests++;
        if (out_sel_a !== 4'b1000 || out_ptr_a !== 2'd3) begin
            fails++;
            $display("FAIL clr_after_w4: got sel=%b ptr=%0d, expected sel=1000 ptr=3",
                     out_sel_a, out_ptr_a);
        end
        send(3'd1, 1'b0);
        out_ready = 1'b0;
        ptr_clr   = 1'b1;
        @(posedge clk);
        #1;
        ptr_clr = 1'b0;
        tests++;
        if (out_valid_a !== 1'b1 || out_sel_a !== 4'b0001 || out_ptr_a !== 2'd0) begin
            fails++;
            $display("FAIL clr_idle_hold_w4: got v=%b sel=%b ptr=%0d, expected v=1 sel=0001 ptr=0",
                     out_valid_a, out_sel_a, out_ptr_a);
        end
        out_ready = 1'b1;
        send(3'd1, 1'b0);
        tests++;
        if (out_sel_a !== 4'b0001 || out_ptr_a !== 2'd0) begin
            fails++;
            $display("FAIL clr_idle_ptr_w4: got sel=%b ptr=%0d, expected sel=0001 ptr=0",
                     out_sel_a, out_ptr_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(3'd3, 1'b0);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid_a !== 1'b0 || out_sel_a !== 4'b0000 || out_valid_b !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: got v4=%b sel4=%b v5=%b, expected v4=0 sel4=0000 v5=0",
                     out_valid_a, out_sel_a, out_valid_b);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(3'd1, 1'b0);
        tests++;
        if (out_sel_a !== 4'b0001 || out_ptr_a !== 2'd0 || out_sel_b !== 5'b00001) begin
            fails++;
            $display("FAIL post_rst: got sel4=%b ptr4=%0d sel5=%b, expected sel4=0001 ptr4=0 sel5=00001",
                     out_sel_a, out_ptr_a, out_sel_b);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_w5_wrap();
        test_clamp();
        test_backpressure();
        test_ptr_clr();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
